// File: rtl/interlock_ctrl_pkg.sv
// Shared pipeline interlock definitions: FSM state type, watchdog width, NOP encoding.
package interlock_ctrl_pkg;

    // Interlock FSM states
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Watchdog counter width; covers MD_TIMEOUT up to 255
    localparam int unsigned WD_W = 8;

    // Instruction encoding loaded into a latch when it is bubbled/flushed
    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage : interlock_ctrl_pkg

// File: rtl/interlock_ctrl_if.sv
// Hazard-request / stage-control bundle between the pipeline and the interlock controller.
//   master : pipeline/hazard side, drives i_* requests, receives o_* controls
//   slave  : interlock controller, receives i_* requests, drives o_* controls
interface interlock_ctrl_if;

    logic i_load_use_hazard;
    logic i_dx_is_md;
    logic i_dx_md_is_div;
    logic i_md_result_rdy;
    logic i_branch_taken;

    logic o_pc_we;
    logic o_fd_we;
    logic o_fd_flush;
    logic o_dx_we;
    logic o_dx_bubble;
    logic o_xm_bubble;
    logic o_md_ctrl_mult;
    logic o_md_ctrl_div;
    logic o_md_timeout;

    modport master (
        output i_load_use_hazard, i_dx_is_md, i_dx_md_is_div, i_md_result_rdy, i_branch_taken,
        input  o_pc_we, o_fd_we, o_fd_flush, o_dx_we, o_dx_bubble, o_xm_bubble,
               o_md_ctrl_mult, o_md_ctrl_div, o_md_timeout
    );

    modport slave (
        input  i_load_use_hazard, i_dx_is_md, i_dx_md_is_div, i_md_result_rdy, i_branch_taken,
        output o_pc_we, o_fd_we, o_fd_flush, o_dx_we, o_dx_bubble, o_xm_bubble,
               o_md_ctrl_mult, o_md_ctrl_div, o_md_timeout
    );

endinterface : interlock_ctrl_if

// File: rtl/interlock_ctrl_md_watchdog.sv
// Mult/div watchdog: counts enabled cycles since the last clear and flags the
// MD_TIMEOUT-th enabled cycle.
//   clk, rst     : clock, async active-high reset
//   i_clr        : zero the count (wins over i_en)
//   i_en         : count this cycle
//   o_expire_c   : combinational, high in the MD_TIMEOUT-th enabled cycle
module md_watchdog
    import interlock_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    logic [WD_W-1:0] r_cnt;

    // Count register holds the number of enabled cycles already completed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + WD_W'(1);
        end
    end

    // Current cycle is the MD_TIMEOUT-th when MD_TIMEOUT-1 cycles have completed
    assign o_expire_c = i_en && !i_clr && (r_cnt == WD_W'(MD_TIMEOUT - 1));

endmodule : md_watchdog

// File: rtl/interlock_ctrl.sv
// Pipeline interlock controller: turns hazard requests into PC/FD/DX/XM enables
// and bubble/flush controls, issues mult/div start pulses and guards the
// mult/div wait with a watchdog.
//   clk, rst          : clock, async active-high reset
//   bus (slave)       : hazard requests in, stage controls out (combinational)
//   o_stall_cycles    : cycles with PC held (STALL_STATS_EN only)
//   o_flush_count     : taken-branch flushes in RUN (STALL_STATS_EN only)
// Optional feature macro: STALL_STATS_EN
module interlock_ctrl
    import interlock_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40
`ifdef STALL_STATS_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    interlock_ctrl_if.slave    bus
`ifdef STALL_STATS_EN
    , output logic [CNT_W-1:0] o_stall_cycles
    , output logic [CNT_W-1:0] o_flush_count
`endif
);

    state_t r_state;
    state_t w_state_nxt;

    logic w_pc_we, w_fd_we, w_fd_flush, w_dx_we, w_dx_bubble, w_xm_bubble;
    logic w_md_mult, w_md_div, w_md_timeout;
    logic w_wd_clr, w_wd_en, w_wd_expire;

    md_watchdog #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_wd_clr),
        .i_en       (w_wd_en),
        .o_expire_c (w_wd_expire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stage controls
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_we      = 1'b1;
        w_fd_we      = 1'b1;
        w_fd_flush   = 1'b0;
        w_dx_we      = 1'b1;
        w_dx_bubble  = 1'b0;
        w_xm_bubble  = 1'b0;
        w_md_mult    = 1'b0;
        w_md_div     = 1'b0;
        w_md_timeout = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_en      = 1'b0;

        unique case (r_state)
            RUN: begin
                if (bus.i_branch_taken) begin
                    // Younger FD/DX instructions are wrong-path: squash both
                    w_fd_flush  = 1'b1;
                    w_dx_bubble = 1'b1;
                end else if (bus.i_dx_is_md) begin
                    w_md_div    = bus.i_dx_md_is_div;
                    w_md_mult   = !bus.i_dx_md_is_div;
                    w_pc_we     = 1'b0;
                    w_fd_we     = 1'b0;
                    w_dx_we     = 1'b0;
                    w_xm_bubble = 1'b1;
                    w_wd_clr    = 1'b1;
                    w_state_nxt = MD_WAIT;
                end else if (bus.i_load_use_hazard) begin
                    w_pc_we     = 1'b0;
                    w_fd_we     = 1'b0;
                    w_dx_bubble = 1'b1;
                end
            end
            MD_WAIT: begin
                w_wd_en = 1'b1;
                if (bus.i_md_result_rdy) begin
                    w_state_nxt = RUN;
                end else if (w_wd_expire) begin
                    // Release with an undefined result; downstream raises the exception
                    w_md_timeout = 1'b1;
                    w_state_nxt  = RUN;
                end else begin
                    w_pc_we     = 1'b0;
                    w_fd_we     = 1'b0;
                    w_dx_we     = 1'b0;
                    w_xm_bubble = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase

        // Reset forces a safe frozen/bubbled pipeline regardless of state
        if (rst) begin
            w_pc_we      = 1'b0;
            w_fd_we      = 1'b0;
            w_dx_we      = 1'b0;
            w_fd_flush   = 1'b1;
            w_dx_bubble  = 1'b1;
            w_xm_bubble  = 1'b1;
            w_md_mult    = 1'b0;
            w_md_div     = 1'b0;
            w_md_timeout = 1'b0;
        end
    end

    assign bus.o_pc_we        = w_pc_we;
    assign bus.o_fd_we        = w_fd_we;
    assign bus.o_fd_flush     = w_fd_flush;
    assign bus.o_dx_we        = w_dx_we;
    assign bus.o_dx_bubble    = w_dx_bubble;
    assign bus.o_xm_bubble    = w_xm_bubble;
    assign bus.o_md_ctrl_mult = w_md_mult;
    assign bus.o_md_ctrl_div  = w_md_div;
    assign bus.o_md_timeout   = w_md_timeout;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Free-running statistics, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_pc_we) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if ((r_state == RUN) && bus.i_branch_taken) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

endmodule : interlock_ctrl
